// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run controller for the R-type pipeline CPU. It feeds the CPU's next-address
// output back to its fetch address until the end of instruction memory, waits
// for the pipeline to drain, and then streams every register-file word out
// over a valid/ready port. It also supports single-step fetch and a watchdog
// that forces a drain when a program loops forever.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          level-sampled; accepted only in IDLE or DONE
//   step_mode      1 = advance the fetch address only when step is high
//   step           single-step advance; ignored outside RUN or step_mode = 0
//   Output_Addr    next fetch address produced by the CPU
//   Input_Addr     registered fetch address driven to the CPU
//   rf_rd_addr     register-file read index (equals dump_idx)
//   rf_rd_data     combinational register-file read data
//   dump_valid, dump_ready, dump_data, dump_idx
//                  register dump stream, one word per accepted beat
//   busy           high in RUN, DRAIN or DUMP
//   done           high in DONE
//   timeout        sticky watchdog flag, cleared by the next accepted start
//   run_cycles     number of RUN cycles, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int INSTR_MAX    = 128,
  parameter int INSTR_BYTES  = 4,
  parameter int DRAIN_CYCLES = 4,
  parameter int REG_MAX      = 32,
  parameter int REG_W        = 32,
  parameter int TIMEOUT      = 1024,
  localparam int IDX_W       = $clog2(REG_MAX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic [ADDR_W-1:0] Output_Addr,
  output logic [ADDR_W-1:0] Input_Addr,
  output logic [IDX_W-1:0]  rf_rd_addr,
  input  logic [REG_W-1:0]  rf_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [REG_W-1:0]  dump_data,
  output logic [IDX_W-1:0]  dump_idx,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [15:0]       run_cycles
);

  localparam logic [ADDR_W-1:0] END_ADDR     = ADDR_W'(INSTR_MAX - INSTR_BYTES);
  localparam int                DRAIN_W      = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD  = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(REG_MAX - 1);
  // The watchdog compares run_cycles + 1 against TIMEOUT on 17 bits so the
  // increment cannot wrap; TIMEOUT values above 65536 never fire.
  localparam logic [16:0]       TIMEOUT_CMP  = 17'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DUMP,
    S_DONE
  } state_e;

  typedef struct packed {
    logic busy;
    logic done;
    logic valid;
  } flags_t;

  // Status outputs are registered alongside the state so they change on the
  // same edge as the transition and never glitch through a state decode.
  function automatic flags_t flags_of(input state_e s);
    flags_t f;
    f.busy  = (s == S_RUN) || (s == S_DRAIN) || (s == S_DUMP);
    f.done  = (s == S_DONE);
    f.valid = (s == S_DUMP);
    return f;
  endfunction

  state_e             state_q;
  flags_t             flags_q;
  logic [DRAIN_W-1:0] drain_q;
  logic [IDX_W-1:0]   idx_q;
  logic               timeout_q;

  logic               at_end;
  logic               tmo_hit;
  logic               advance;

  assign at_end  = (Input_Addr >= END_ADDR);
  assign tmo_hit = (({1'b0, run_cycles} + 17'd1) == TIMEOUT_CMP);
  assign advance = !step_mode || step;

  // NOTE: every state register below uses non-blocking assignment so all of
  // them sample the pre-edge values; mixing in blocking writes would make the
  // result depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      flags_q    <= flags_of(S_IDLE);
      Input_Addr <= '0;
      run_cycles <= '0;
      timeout_q  <= 1'b0;
      drain_q    <= '0;
      idx_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_RUN;
            flags_q    <= flags_of(S_RUN);
            Input_Addr <= '0;
            run_cycles <= '0;
            timeout_q  <= 1'b0;
          end
        end

        S_RUN: begin
          if (run_cycles != 16'hFFFF) begin
            run_cycles <= run_cycles + 16'd1;
          end
          // End-of-memory takes priority over the watchdog, and a step that
          // arrives on the end-detect cycle is deliberately dropped.
          if (at_end) begin
            state_q <= S_DRAIN;
            flags_q <= flags_of(S_DRAIN);
            drain_q <= DRAIN_LOAD;
          end else if (tmo_hit) begin
            timeout_q <= 1'b1;
            state_q   <= S_DRAIN;
            flags_q   <= flags_of(S_DRAIN);
            drain_q   <= DRAIN_LOAD;
          end else if (advance) begin
            Input_Addr <= Output_Addr;
          end
        end

        S_DRAIN: begin
          if (drain_q == '0) begin
            state_q <= S_DUMP;
            flags_q <= flags_of(S_DUMP);
            idx_q   <= '0;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end

        S_DUMP: begin
          if (dump_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= S_DONE;
              flags_q <= flags_of(S_DONE);
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          flags_q <= flags_of(S_IDLE);
        end
      endcase
    end
  end

  assign rf_rd_addr = idx_q;
  assign dump_idx   = idx_q;
  assign dump_data  = rf_rd_data;
  assign dump_valid = flags_q.valid;
  assign busy       = flags_q.busy;
  assign done       = flags_q.done;
  assign timeout    = timeout_q;

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Synthesizable run controller for the R-type pipeline CPU. It generalises the bench-driven fetch loop into hardware: it feeds the CPU's next-address output back to its fetch address until the end of instruction memory, then drains the pipeline, then streams every register-file word out over a valid/ready port. It sits between the CPU top and the bench or host, and adds single-step, timeout and back-pressured register dump, which the plain bench loop lacks.

## Interface
- `ADDR_W`, 32, fetch address width
- `INSTR_MAX`, 128, instruction memory size in bytes
- `INSTR_BYTES`, 4, bytes per instruction; END_ADDR = INSTR_MAX - INSTR_BYTES
- `DRAIN_CYCLES`, 4, cycles waited after last fetch; must be ≥ 1
- `REG_MAX`, 32, register-file words to dump
- `REG_W`, 32, register width
- `TIMEOUT`, 1024, maximum RUN cycles before forced drain; must be ≥ 1
- `clk  in  1`  rising-edge clock
- `rst_n  in  1`  asynchronous, active-low reset
- `start  in  1`  level-sampled; accepted only in IDLE or DONE
- `step_mode  in  1`  1 = advance the address only on `step`
- `step  in  1`  single-step advance pulse; ignored when `step_mode` = 0
- `Output_Addr  in  ADDR_W`  next fetch address from the CPU
- `Input_Addr  out  ADDR_W`  fetch address to the CPU (registered)
- `rf_rd_addr  out  $clog2(REG_MAX)`  register-file read index
- `rf_rd_data  in  REG_W`  combinational register-file read data
- `dump_valid  out  1`, `dump_ready  in  1`, `dump_data  out  REG_W`, `dump_idx  out  $clog2(REG_MAX)`  register dump stream
- `busy  out  1`  high in RUN, DRAIN or DUMP
- `done  out  1`  high in DONE
- `timeout  out  1`  sticky; set when the watchdog fires, cleared on the next accepted `start`
- `run_cycles  out  16`  RUN cycle count, saturating at 0xFFFF

## Operation
- States: IDLE → RUN → DRAIN → DUMP → DONE. DONE with `start` goes back to RUN.
- **IDLE/DONE + start:**
  - Input_Addr ← 0, run_cycles ← 0, timeout ← 0; enter RUN.
- **RUN, each cycle:**
  - run_cycles increments.
  - If Input_Addr ≥ END_ADDR (unsigned), enter DRAIN and leave Input_Addr unchanged.
  - Else, if run_cycles + 1 == TIMEOUT, set timeout and enter DRAIN.
  - Else, if the advance is enabled (step_mode = 0, or step = 1), Input_Addr ← Output_Addr. Otherwise hold.
- **DRAIN:**
  - A counter loads DRAIN_CYCLES-1 on entry and decrements each cycle.
  - At 0, enter DUMP with idx = 0.
  - Input_Addr holds throughout.
- **DUMP:**
  - rf_rd_addr = dump_idx = idx; dump_data = rf_rd_data (combinational passthrough); dump_valid = 1.
  - A beat transfers on valid & ready, then idx increments.
  - The transfer at idx = REG_MAX-1 enters DONE.
  - While ready = 0, idx, rf_rd_addr and valid hold stable.
- `start` outside IDLE/DONE is ignored. `step` outside RUN is ignored.
- Output_Addr values that jump backwards are followed verbatim. The timeout bounds loops.

## Timing
- **Reset values:**
  - Input_Addr = 0, rf_rd_addr = 0, dump_idx = 0, dump_data follows rf_rd_data.
  - dump_valid = 0, busy = 0, done = 0, timeout = 0, run_cycles = 0.
  - State = IDLE.
- Assertion of rst_n mid-operation returns everything to these values immediately. A dump in progress is abandoned.
- **Latencies:**
  - `start` to first Input_Addr update from Output_Addr: 1 cycle (the RUN entry edge sets 0, the next edge loads Output_Addr).
  - Last RUN cycle to first dump_valid: exactly DRAIN_CYCLES cycles.
  - Dump with ready held high: REG_MAX cycles; `done` rises on the edge after the final beat.
- If the end-address test and the timeout coincide in the same cycle, the end-address test wins and timeout stays 0.
- In step mode, a `step` on the cycle the end condition is detected is dropped.
- `start` arriving in the same cycle DONE is entered is not accepted. It must be sampled while in DONE.

## Test plan
- **Linear program** (Output_Addr = Input_Addr + 4), DRAIN_CYCLES = 4, dump_ready = 1:
  - Input_Addr steps 0,4,…,124.
  - RUN lasts 32 cycles, run_cycles = 32, timeout = 0.
  - dump_valid rises 4 cycles after RUN ends; 32 beats with dump_idx 0..31 and dump_data equal to the preloaded R[i]; then done = 1.
- **Back-pressure:** dump_ready toggles 1,0,0,1,…:
  - While ready = 0, dump_idx and dump_data are stable.
  - All 32 words are delivered in order, with no duplicates or skips.
- **Infinite loop** (Output_Addr = 8 constant), TIMEOUT = 50:
  - Forced DRAIN after 50 RUN cycles, timeout = 1, run_cycles = 50, and the dump still completes.
- **Step mode:** step_mode = 1, pulse `step` every 3rd cycle:
  - Input_Addr changes only on the cycle after each pulse.
  - Reaching 124 takes 31 pulses.
- **Reset mid-DUMP** (rst_n low at idx = 10):
  - All outputs return to their reset values in the same cycle.
  - A new `start` reruns from address 0, and the dump begins at idx 0.
- **Restart from DONE:**
  - `start` in DONE clears timeout and run_cycles and repeats the linear sequence identically.
